// File: rtl/decode_issue.sv
// decode_issue: CBox16 decode/issue stage with a register-retire scoreboard that stalls on RAW/WAW hazards.
module decode_issue #(
    parameter int NREGS = 8,
    parameter int IMM_W = 16,
    localparam int RW = $clog2(NREGS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [15:0]      in_instr,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_op,
    output logic [RW-1:0]    out_rs1,
    output logic [RW-1:0]    out_rs2,
    output logic [RW-1:0]    out_ws,
    output logic             out_we,
    output logic             out_fl_en,
    output logic [IMM_W-1:0] out_imm,
    output logic             out_illegal,
    input  logic             wb_valid,
    input  logic [RW-1:0]    wb_ws,
    output logic             halted
);
    logic [3:0]       op;
    logic [RW-1:0]    rd, rs1, rs2, d_rs1, d_rs2, d_ws;
    logic             rd1, rd2, wr, fl, ill, d_we, hazard, accept;
    logic [IMM_W-1:0] d_imm;
    logic [NREGS-1:0] pending, eff;

    assign op  = in_instr[15:12];
    assign rd  = in_instr[11:9];
    assign rs1 = in_instr[8:6];
    assign rs2 = in_instr[5:3];

    assign rd1   = op != 4'h0 && op <= 4'hB;
    assign rd2   = (op != 4'h0 && op <= 4'h7) || op == 4'hA || op == 4'hB;
    assign wr    = (op != 4'h0 && op <= 4'h9) || op == 4'hC;
    assign fl    = op != 4'h0 && op <= 4'h8;
    assign ill   = op == 4'hD || op == 4'hE;
    assign d_we  = wr && rd != '0;
    assign d_rs1 = rd1 ? rs1 : '0;
    assign d_rs2 = rd2 ? rs2 : '0;
    assign d_ws  = wr ? rd : '0;
    assign d_imm = (op == 4'h8 || op == 4'h9) ? IMM_W'($signed(in_instr[5:0])) :
                   (op == 4'hA || op == 4'hB) ? IMM_W'($signed(in_instr[2:0])) :
                   op == 4'hC ? IMM_W'({in_instr[8:0], 7'b0}) : '0;

    // A retiring writeback releases its register in the same cycle it is seen
    assign eff    = pending & ~(wb_valid ? NREGS'(1) << wb_ws : '0);
    assign hazard = (rd1 && eff[rs1]) || (rd2 && eff[rs2]) || (d_we && eff[rd]);
    assign in_ready = rst_n && !halted && !hazard && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pending     <= '0;
            out_valid   <= 1'b0;
            out_op      <= '0;
            out_rs1     <= '0;
            out_rs2     <= '0;
            out_ws      <= '0;
            out_we      <= 1'b0;
            out_fl_en   <= 1'b0;
            out_imm     <= '0;
            out_illegal <= 1'b0;
            halted      <= 1'b0;
        end else begin
            pending <= (eff | (accept && d_we ? NREGS'(1) << rd : '0)) & ~NREGS'(1);
            if (accept) begin
                out_valid   <= 1'b1;
                out_op      <= op;
                out_rs1     <= d_rs1;
                out_rs2     <= d_rs2;
                out_ws      <= d_ws;
                out_we      <= d_we;
                out_fl_en   <= fl;
                out_imm     <= d_imm;
                out_illegal <= ill;
                halted      <= op == 4'hF;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule
